pipeline_control_unit: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (IF/DE/EX/MEM/WB).
- Combines the load-use stall request from hazard detection, the taken-branch/jump redirect from EX, and a ready handshake from the data memory.
- Drives per-stage pipeline-register enable and flush controls.
- Also holds saturating performance counters and a sticky memory-timeout error flag.

---
 rtl/pipeline_control_unit_if.sv | 32 +++
 rtl/pipeline_control_unit.sv | 81 ++++++++
 tb/tb_pipeline_control_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_unit_if.sv
// Handshake and control bundle between the pipeline datapath and its stall/flush sequencer.
// The master side is the sequencer; the slave side is the datapath that raises requests.
interface pipeline_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             HDUStall;
  logic             NextPCSrc_ex;
  logic             DMRq_mem;
  logic             DMReady;
  logic             pc_en;
  logic             fd_en;
  logic             de_en;
  logic             em_en;
  logic             mw_en;
  logic             fd_flush;
  logic             de_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  HDUStall, NextPCSrc_ex, DMRq_mem, DMReady,
    output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush,
    output mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    output HDUStall, NextPCSrc_ex, DMRq_mem, DMReady,
    input  pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush,
    input  mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational enable/flush decode, zero latency.
// Backpressure: a data-memory access that is not ready freezes every stage until ready or timeout.
module pipeline_control_unit #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic                     clk,
  input logic                     rst,
  pipeline_control_unit_if.master bus
);
  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic timeout_hit;
  logic mem_block;
  logic hold;
  logic branch;
  logic load_use;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush;

  // A timed-out wait is released exactly like a ready cycle, so one hold term covers both states.
  always_comb begin
    timeout_hit = (state == MEM_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT));
    mem_block   = bus.DMRq_mem && !bus.DMReady;
    hold        = mem_block && !timeout_hit;
    branch      = !hold && bus.NextPCSrc_ex;
    load_use    = !hold && !bus.NextPCSrc_ex && bus.HDUStall;
    pc_en       = !rst && !hold && !load_use;
    fd_en       = !rst && !hold && !load_use;
    de_en       = !rst && !hold;
    em_en       = !rst && !hold;
    mw_en       = !rst && !hold;
    fd_flush    = !rst && branch;
    de_flush    = !rst && (branch || load_use);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      if (hold) begin
        state    <= MEM_WAIT;
        wait_cnt <= (state == RUN) ? WAIT_W'(1) : wait_cnt + WAIT_W'(1);
      end else begin
        state    <= RUN;
        wait_cnt <= '0;
      end
      if (timeout_hit && mem_block) begin
        mem_err_q <= 1'b1;
      end
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (branch && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.fd_en     = fd_en;
  assign bus.de_en     = de_en;
  assign bus.em_en     = em_en;
  assign bus.mw_en     = mw_en;
  assign bus.fd_flush  = fd_flush;
  assign bus.de_flush  = de_flush;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench driving two sequencers in lockstep: a default one and a narrow
// one (2-bit counters, 4-cycle timeout) to reach saturation and timeout quickly.
module tb_pipeline_control_unit;
  localparam logic [6:0] FRZ = 7'b00000_00;
  localparam logic [6:0] ALL = 7'b11111_00;
  localparam logic [6:0] BR  = 7'b11111_11;
  localparam logic [6:0] LU  = 7'b00111_01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hdu = 1'b0;
  logic br  = 1'b0;
  logic rq  = 1'b0;
  logic rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(16)) bus_a ();
  pipeline_control_unit_if #(.CNT_W(2))  bus_b ();

  assign bus_a.HDUStall     = hdu;
  assign bus_a.NextPCSrc_ex = br;
  assign bus_a.DMRq_mem     = rq;
  assign bus_a.DMReady      = rdy;
  assign bus_b.HDUStall     = hdu;
  assign bus_b.NextPCSrc_ex = br;
  assign bus_b.DMRq_mem     = rq;
  assign bus_b.DMReady      = rdy;

  pipeline_control_unit #(.CNT_W(16), .TIMEOUT(64)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  pipeline_control_unit #(.CNT_W(2), .TIMEOUT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  logic [6:0] ctrl_a;
  logic [6:0] ctrl_b;
  assign ctrl_a = {bus_a.pc_en, bus_a.fd_en, bus_a.de_en, bus_a.em_en, bus_a.mw_en,
                   bus_a.fd_flush, bus_a.de_flush};
  assign ctrl_b = {bus_b.pc_en, bus_b.fd_en, bus_b.de_en, bus_b.em_en, bus_b.mw_en,
                   bus_b.fd_flush, bus_b.de_flush};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/a"}, {9'd0, ctrl_a}, {9'd0, e.a});
      chk({e.tag, "/b"}, {9'd0, ctrl_b}, {9'd0, e.b});
    end
  endtask

  // One clock of stimulus; outputs are sampled on the falling edge of the same cycle.
  task automatic step(input logic h, input logic b, input logic q, input logic r,
                      input logic [6:0] ea, input logic [6:0] eb, input string tag);
    @(posedge clk);
    #1;
    hdu = h;
    br  = b;
    rq  = q;
    rdy = r;
    sb.push_back('{a: ea, b: eb, tag: tag});
    @(negedge clk);
    compare_pop();
  endtask

  task automatic rst_pulse(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.push_back('{a: FRZ, b: FRZ, tag: {tag, "_ctrl"}});
    @(negedge clk);
    compare_pop();
    chk({tag, "_stall_a"}, bus_a.stall_cnt, 16'd0);
    chk({tag, "_flush_a"}, bus_a.flush_cnt, 16'd0);
    chk({tag, "_err_a"}, {15'd0, bus_a.mem_err}, 16'd0);
    chk({tag, "_stall_b"}, {14'd0, bus_b.stall_cnt}, 16'd0);
    chk({tag, "_err_b"}, {15'd0, bus_b.mem_err}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hdu = 1'b0;
    br  = 1'b0;
    rq  = 1'b0;
    rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_pulse("reset0");
    step(0, 0, 0, 0, ALL, ALL, "idle0");

    // Load-use stall for one cycle, then free running.
    step(1, 0, 0, 0, LU, LU, "lu");
    step(0, 0, 0, 0, ALL, ALL, "lu_after");
    chk("lu_stall_a", bus_a.stall_cnt, 16'd1);
    chk("lu_stall_b", {14'd0, bus_b.stall_cnt}, 16'd1);
    chk("lu_flush_a", bus_a.flush_cnt, 16'd0);

    // Branch wins over a simultaneous hazard.
    rst_pulse("reset1");
    step(1, 1, 0, 0, BR, BR, "br_hdu");
    step(0, 0, 0, 0, ALL, ALL, "br_after");
    chk("br_flush_a", bus_a.flush_cnt, 16'd1);
    chk("br_stall_a", bus_a.stall_cnt, 16'd0);

    // Memory wait of three frozen cycles, then back-to-back access running into timeout on dut_b.
    rst_pulse("reset2");
    step(0, 0, 1, 0, FRZ, FRZ, "mw_run");
    step(0, 0, 1, 0, FRZ, FRZ, "mw_w1");
    step(0, 0, 1, 0, FRZ, FRZ, "mw_w2");
    step(0, 0, 1, 1, ALL, ALL, "mw_ready");
    step(0, 0, 1, 0, FRZ, FRZ, "b2b_run");
    chk("mw_stall_a", bus_a.stall_cnt, 16'd3);
    chk("mw_stall_b", {14'd0, bus_b.stall_cnt}, 16'd3);
    chk("mw_err_a", {15'd0, bus_a.mem_err}, 16'd0);
    step(0, 0, 1, 0, FRZ, FRZ, "b2b_w1");
    step(0, 0, 1, 0, FRZ, FRZ, "b2b_w2");
    step(0, 0, 1, 0, FRZ, FRZ, "b2b_w3");
    step(0, 0, 1, 0, FRZ, ALL, "to_w4");
    chk("to_err_b_pre", {15'd0, bus_b.mem_err}, 16'd0);
    step(0, 0, 1, 0, FRZ, FRZ, "to_reenter");
    chk("to_err_b", {15'd0, bus_b.mem_err}, 16'd1);
    step(0, 0, 0, 0, ALL, ALL, "rq_drop");
    step(0, 0, 0, 0, ALL, ALL, "to_idle");
    chk("to_err_b_sticky", {15'd0, bus_b.mem_err}, 16'd1);
    chk("to_err_a", {15'd0, bus_a.mem_err}, 16'd0);
    chk("to_stall_a", bus_a.stall_cnt, 16'd9);
    chk("to_stall_b_sat", {14'd0, bus_b.stall_cnt}, 16'd3);

    // Reset in the middle of a wait overrides the frozen request.
    step(0, 0, 1, 0, FRZ, FRZ, "mid_run");
    step(0, 0, 1, 0, FRZ, FRZ, "mid_w1");
    rst_pulse("reset_mid");
    step(0, 0, 0, 0, ALL, ALL, "mid_after");
    chk("mid_stall_a", bus_a.stall_cnt, 16'd0);

    // A branch held across a wait is acted on only in the ready cycle.
    step(0, 1, 1, 0, FRZ, FRZ, "pb_run");
    step(1, 1, 1, 0, FRZ, FRZ, "pb_w1");
    step(0, 1, 1, 1, BR, BR, "pb_ready");
    step(0, 0, 0, 0, ALL, ALL, "pb_after");
    chk("pb_flush_a", bus_a.flush_cnt, 16'd1);
    chk("pb_stall_a", bus_a.stall_cnt, 16'd2);

    // Five flushes saturate the 2-bit counter.
    rst_pulse("reset3");
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, BR, BR, "sat_br");
    end
    step(0, 0, 0, 0, ALL, ALL, "sat_after");
    chk("sat_flush_a", bus_a.flush_cnt, 16'd5);
    chk("sat_flush_b", {14'd0, bus_b.flush_cnt}, 16'd3);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
